load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 20, meaning word-address width of the data memory port.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have port req_valid, input, 1, pipeline presents a load/store.
REQ-005 The block SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 The block SHALL have ports req_we (input, 1, 1 = store), req_funct3 (input, 3, RV32I size/sign code), req_addr (input, 32, byte address) and req_wdata (input, 32, store data).
REQ-007 The block SHALL have ports rsp_valid (output, 1, one-cycle completion pulse), rsp_rdata (output, 32, load result) and rsp_err (output, 1, fault or illegal funct3).
REQ-008 The block SHALL have ports mem_cs (output, 1, active-low select), mem_wr (output, 1, 0 = write, 1 = read) and mem_mask (output, 4, byte enables).
REQ-009 The block SHALL have ports mem_addr (output, ADDR_W, word address), mem_data_wr (output, 32, write data) and mem_data_rd (input, 32, asynchronous read data, valid in the same cycle as the select).

Function
REQ-010 The FSM SHALL have states IDLE, ACC0, ACC1 and RESP; req_ready SHALL be 1 only in IDLE, and acceptance SHALL be req_valid&&req_ready.
REQ-011 On acceptance, the block SHALL register we, funct3, the rotated write data, offset = addr[1:0] and word = addr[ADDR_W+1:2].
REQ-012 Illegal funct3 SHALL be loads 011/110/111 and stores other than 000/001/010.
REQ-013 A fault SHALL be an illegal funct3, addr >= 2^(ADDR_W+2), or a last accessed byte beyond that limit; on a fault the block SHALL go IDLE->RESP with rsp_err=1 and perform no memory access.
REQ-014 An access SHALL be split when offset+size > 4 (half with offset 3; word with offset != 0); otherwise it SHALL be single.
REQ-015 In ACC0 the block SHALL drive mem_cs=0, mem_wr=!we, mem_addr=word, mem_mask=first-word enables (bits offset..min(offset+size-1,3)).
REQ-016 For a split access, ACC0 SHALL go to ACC1; in ACC1 the block SHALL drive mem_addr=word+1, mem_mask=the remaining low enables, same mem_wr. Otherwise ACC0 SHALL go to RESP.
REQ-017 mem_data_wr SHALL be req_wdata rotated left by 8*offset in both ACC0 and ACC1.
REQ-018 For loads, mem_data_rd SHALL be captured at the end of ACC0 (rd0) and of ACC1 (rd1); raw = ({rd1,rd0} >> 8*offset)[31:0].
REQ-019 The load result SHALL be: LB/LH sign-extend raw[7:0]/raw[15:0]; LBU/LHU zero-extend; LW = raw.
REQ-020 RESP SHALL assert rsp_valid for exactly one cycle, then go to IDLE; rsp_rdata SHALL be 0 for stores and faults.
REQ-021 Latency from the acceptance cycle N SHALL be: single access rsp_valid at N+2, split at N+3, fault at N+1.
REQ-022 A new request SHALL be accepted no earlier than the cycle after RESP; back-to-back throughput SHALL be one request per 3 cycles (single access).
REQ-023 In IDLE and RESP the block SHALL drive mem_cs=1, mem_wr=1, mem_mask=0, mem_addr=0, mem_data_wr=0.
REQ-024 All mem_* outputs SHALL be registered (stable across the whole cycle, including the falling-edge write point).
REQ-025 The response path SHALL have no backpressure; the pipeline consumes rsp_valid when it is asserted.

Reset
REQ-026 While rst=1 at a rising edge, the next state SHALL be IDLE, with rsp_valid=0, rsp_err=0, rsp_rdata=0 and the mem_* outputs at their idle values.
REQ-027 A reset during ACC0 or ACC1 SHALL abandon the operation: the second half of a split store SHALL NOT be written and no response SHALL be issued.
REQ-028 req_ready SHALL be 0 in any cycle with rst=1.

Structure
REQ-029 Shared package lsu_pkg SHALL hold the state enum, the funct3 enum (LB, LH, LW, LBU, LHU, SB, SH, SW) and MEM_AW=20.
REQ-030 Combinational mask generation, write rotation and load extraction SHALL live in sub-module lsu_align; the FSM and registers SHALL stay in load_store_unit.

Verification
REQ-031 After memory reset (all words 0xdeadbeef): LB addr 0x0 -> rsp_rdata=0xFFFFFFEF at N+2; LBU addr 0x1 -> 0x000000BE.
REQ-032 SW 0x11223344 to addr 0x6 -> ACC0 word 1 mask 1100, ACC1 word 2 mask 0011, mem_data_wr=0x33441122; then LW addr 0x6 -> 0x11223344 at N+3.
REQ-033 SH 0xA5A5 to addr 0x3 -> split, masks 1000/0001; LHU addr 0x3 -> 0x0000A5A5; LH -> 0xFFFFA5A5.
REQ-034 LW addr 0x00400000 and LW addr 0x003FFFFE -> rsp_err=1 at N+1, mem_cs held 1 throughout.
REQ-035 Split SW with rst asserted during ACC0 -> no ACC1 write (word+1 still 0xdeadbeef), rsp_valid never asserted, req_ready=1 the cycle after rst drops.
REQ-036 req_funct3=011 with req_we=1 -> rsp_err=1 at N+1, no write.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access codes and memory geometry.
package lsu_pkg;

    localparam int MEM_AW = 20;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } state_e;

    // Encoded as {we, funct3} so that loads and stores that share a funct3 value stay distinct.
    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } funct3_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: legality, byte enables, store-data rotation and load extraction.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rd0,
    input  logic [31:0] rd1,
    output logic        illegal,
    output logic [2:0]  size,
    output logic [3:0]  mask0,
    output logic [3:0]  mask1,
    output logic        split,
    output logic [31:0] wdata_rot,
    output logic [31:0] rdata
);

    logic [3:0]  ones;
    logic [7:0]  lanes;
    logic [63:0] wr_wide;
    logic [63:0] rd_wide;
    logic [31:0] raw;

    // NOTE: every output gets a default before the case so no latch can be inferred.
    always_comb begin
        illegal = 1'b1;
        case ({we, funct3})
            LB, LH, LW, LBU, LHU, SB, SH, SW: illegal = 1'b0;
            default:                          illegal = 1'b1;
        endcase

        case (funct3[1:0])
            2'b00:   begin size = 3'd1; ones = 4'b0001; end
            2'b01:   begin size = 3'd2; ones = 4'b0011; end
            default: begin size = 3'd4; ones = 4'b1111; end
        endcase

        // Lanes past byte 3 spill into the next word.
        lanes = {4'b0000, ones} << offset;
        mask0 = lanes[3:0];
        mask1 = lanes[7:4];
        split = |lanes[7:4];

        wr_wide   = {wdata, wdata} << {offset, 3'b000};
        wdata_rot = wr_wide[63:32];

        rd_wide = {rd1, rd0} >> {offset, 3'b000};
        raw     = rd_wide[31:0];

        rdata = 32'h0;
        case ({we, funct3})
            LB:      rdata = {{24{raw[7]}}, raw[7:0]};
            LH:      rdata = {{16{raw[15]}}, raw[15:0]};
            LW:      rdata = raw;
            LBU:     rdata = {24'h0, raw[7:0]};
            LHU:     rdata = {16'h0, raw[15:0]};
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, misaligned accesses split over two word cycles.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = MEM_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_cs,
    output logic              mem_wr,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data_wr,
    input  logic [31:0]       mem_data_rd
);

    state_e state, state_next;

    logic              we_q, err_q;
    logic [2:0]        funct3_q;
    logic [1:0]        offset_q;
    logic [ADDR_W-1:0] word_q;
    logic [31:0]       wrot_q, rd0_q, rd1_q;

    logic              accept, fault;
    logic              we_d;
    logic [2:0]        funct3_d;
    logic [1:0]        offset_d;
    logic [ADDR_W-1:0] word_d;
    logic [31:0]       wrot_d;
    logic [32:0]       last_byte;

    logic              illegal, split;
    logic [2:0]        size;
    logic [3:0]        mask0, mask1;
    logic [31:0]       wdata_rot, load_data;

    logic              cs_d, wr_d;
    logic [3:0]        mask_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       data_d;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // While accepting, the request itself feeds the align logic so ACC0 bus values can be registered.
    assign we_d      = accept ? req_we : we_q;
    assign funct3_d  = accept ? req_funct3 : funct3_q;
    assign offset_d  = accept ? req_addr[1:0] : offset_q;
    assign word_d    = accept ? req_addr[ADDR_W+1:2] : word_q;
    assign wrot_d    = accept ? wdata_rot : wrot_q;
    assign last_byte = {1'b0, req_addr} + {30'h0, size} - 33'd1;
    assign fault     = illegal || (|(last_byte >> (ADDR_W + 2)));

    lsu_align u_align (
        .we        (we_d),
        .funct3    (funct3_d),
        .offset    (offset_d),
        .wdata     (req_wdata),
        .rd0       (rd0_q),
        .rd1       (rd1_q),
        .illegal   (illegal),
        .size      (size),
        .mask0     (mask0),
        .mask1     (mask1),
        .split     (split),
        .wdata_rot (wdata_rot),
        .rdata     (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = fault ? RESP : ACC0;
            ACC0:    state_next = split ? ACC1 : RESP;
            ACC1:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus values are decoded from the upcoming state so the registered outputs line up with it.
    always_comb begin
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        mask_d = 4'b0000;
        addr_d = '0;
        data_d = 32'h0;
        case (state_next)
            ACC0: begin
                cs_d   = 1'b0;
                wr_d   = !we_d;
                mask_d = mask0;
                addr_d = word_d;
                data_d = wrot_d;
            end
            ACC1: begin
                cs_d   = 1'b0;
                wr_d   = !we_d;
                mask_d = mask1;
                addr_d = word_d + ADDR_W'(1);
                data_d = wrot_d;
            end
            default: ;
        endcase

        rsp_valid = (state == RESP);
        rsp_err   = (state == RESP) && err_q;
        rsp_rdata = ((state == RESP) && !err_q && !we_q) ? load_data : 32'h0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_cs      <= 1'b1;
            mem_wr      <= 1'b1;
            mem_mask    <= 4'b0000;
            mem_addr    <= '0;
            mem_data_wr <= 32'h0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            word_q      <= '0;
            wrot_q      <= 32'h0;
            rd0_q       <= 32'h0;
            rd1_q       <= 32'h0;
        end else begin
            mem_cs      <= cs_d;
            mem_wr      <= wr_d;
            mem_mask    <= mask_d;
            mem_addr    <= addr_d;
            mem_data_wr <= data_d;
            if (accept) begin
                we_q     <= req_we;
                err_q    <= fault;
                funct3_q <= req_funct3;
                offset_q <= req_addr[1:0];
                word_q   <= req_addr[ADDR_W+1:2];
                wrot_q   <= wdata_rot;
            end
            if (state == ACC0) rd0_q <= mem_data_rd;
            if (state == ACC1) rd1_q <= mem_data_rd;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-addressed reference memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int          AW    = MEM_AW;
    localparam longint      LIM   = 64'd1 << (AW + 2);
    localparam logic [31:0] LIM32 = 32'(LIM);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          mem_cs, mem_wr;
    logic [3:0]    mem_mask;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_wr, mem_data_rd;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_cs      (mem_cs),
        .mem_wr      (mem_wr),
        .mem_mask    (mem_mask),
        .mem_addr    (mem_addr),
        .mem_data_wr (mem_data_wr),
        .mem_data_rd (mem_data_rd)
    );

    // Device memory: 64 words, low words for the bottom of the space, top words alias to 62/63.
    logic [31:0] dmem [64];
    logic        mem_clear;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] mask);
        logic [31:0] w = old;
        for (int i = 0; i < 4; i++) if (mask[i]) w[8*i +: 8] = data[8*i +: 8];
        return w;
    endfunction

    always @(negedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'hdeadbeef;
        end else if (!mem_cs && !mem_wr) begin
            dmem[mem_addr[5:0]] <= merge(dmem[mem_addr[5:0]], mem_data_wr, mem_mask);
        end
        mem_data_rd <= dmem[mem_addr[5:0]];
    end

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain byte memory with the reset pattern as default.
    logic [7:0] ref_b [int unsigned];

    function automatic logic [7:0] ref_byte(input int unsigned a);
        logic [31:0] d = 32'hdeadbeef;
        if (ref_b.exists(a)) return ref_b[a];
        return d[8*(a%4) +: 8];
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0]   obs_rdata;
    logic          obs_err;
    int            obs_lat, obs_nacc, accept_cyc;
    logic [AW-1:0] acc_addr [2];
    logic [3:0]    acc_mask [2];
    logic [31:0]   acc_data [2];

    // Issue one request from a falling edge, follow it to its response and compare with the model.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int          size, exp_lat, exp_nacc, guard, k;
        logic        illegal, fault, split, got;
        logic [31:0] v, exp_rd;

        size     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        illegal  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        fault    = illegal || (longint'(addr) + longint'(size) > LIM);
        split    = (int'(addr % 4) + size) > 4;
        exp_lat  = fault ? 1 : split ? 3 : 2;
        exp_nacc = fault ? 0 : split ? 2 : 1;
        exp_rd   = 32'h0;
        if (!fault && !we) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_byte(addr + i);
            case (f3)
                3'd0:    exp_rd = {{24{v[7]}}, v[7:0]};
                3'd1:    exp_rd = {{16{v[15]}}, v[15:0]};
                default: exp_rd = v;
            endcase
        end
        if (!fault && we)
            for (int i = 0; i < size; i++) ref_b[addr + i] = wdata[8*i +: 8];

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        guard      = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready", req_ready, 1'b1);
        accept_cyc = cyc;
        @(posedge clk);

        k = 0; obs_nacc = 0; got = 1'b0; obs_rdata = 32'hx; obs_err = 1'bx;
        while (!got && k < 8) begin
            @(negedge clk);
            k++;
            req_valid = 1'b0;
            if (!mem_cs) begin
                if (obs_nacc < 2) begin
                    acc_addr[obs_nacc] = mem_addr;
                    acc_mask[obs_nacc] = mem_mask;
                    acc_data[obs_nacc] = mem_data_wr;
                end
                obs_nacc++;
            end
            if (rsp_valid) begin
                got       = 1'b1;
                obs_rdata = rsp_rdata;
                obs_err   = rsp_err;
                check("resp_bus_idle", {mem_cs, mem_wr, mem_mask, 26'(mem_addr)}, {6'b110000, 26'h0});
                check("resp_wdata_idle", mem_data_wr, 32'h0);
            end
        end
        obs_lat = k;
        check("latency", obs_lat, exp_lat);
        check("mem_accesses", obs_nacc, exp_nacc);
        check("rsp_err", obs_err, fault);
        check("rsp_rdata", obs_rdata, exp_rd);
        @(negedge clk);
        check("rsp_one_cycle", rsp_valid, 1'b0);
    endtask

    initial begin
        int   first_acc, seen;
        logic we;
        logic [31:0] addr;

        rst = 1'b1; mem_clear = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_ready", req_ready, 1'b0);
        check("reset_rsp", {rsp_valid, rsp_err}, 2'b00);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_bus", {mem_cs, mem_wr, mem_mask, 26'(mem_addr)}, {6'b110000, 26'h0});
        rst = 1'b0; mem_clear = 1'b0;
        @(negedge clk);

        do_req(1'b0, 3'b000, 32'h0, 32'h0);
        first_acc = accept_cyc;
        check("lb_0", obs_rdata, 32'hFFFFFFEF);
        check("lb_0_latency", obs_lat, 2);
        do_req(1'b0, 3'b100, 32'h1, 32'h0);
        check("lbu_1", obs_rdata, 32'h000000BE);
        check("throughput", accept_cyc - first_acc, 3);

        do_req(1'b1, 3'b010, 32'h6, 32'h11223344);
        check("sw6_acc0", {12'(acc_addr[0]), acc_mask[0]}, {12'd1, 4'b1100});
        check("sw6_acc1", {12'(acc_addr[1]), acc_mask[1]}, {12'd2, 4'b0011});
        check("sw6_data0", acc_data[0], 32'h33441122);
        check("sw6_data1", acc_data[1], 32'h33441122);
        do_req(1'b0, 3'b010, 32'h6, 32'h0);
        check("lw6", obs_rdata, 32'h11223344);
        check("lw6_latency", obs_lat, 3);

        do_req(1'b1, 3'b001, 32'h3, 32'h0000A5A5);
        check("sh3_masks", {acc_mask[0], acc_mask[1]}, {4'b1000, 4'b0001});
        do_req(1'b0, 3'b101, 32'h3, 32'h0);
        check("lhu3", obs_rdata, 32'h0000A5A5);
        do_req(1'b0, 3'b001, 32'h3, 32'h0);
        check("lh3", obs_rdata, 32'hFFFFA5A5);

        do_req(1'b0, 3'b010, 32'h00400000, 32'h0);
        check("lw_beyond_err", {obs_err, 4'(obs_nacc)}, {1'b1, 4'd0});
        do_req(1'b0, 3'b010, 32'h003FFFFE, 32'h0);
        check("lw_straddle_err", {obs_err, 4'(obs_nacc)}, {1'b1, 4'd0});
        do_req(1'b1, 3'b011, 32'h10, 32'hCAFEF00D);
        check("store_f3_011_err", {obs_err, 4'(obs_nacc)}, {1'b1, 4'd0});

        // Reset in the middle of a split store: only the first word may change.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h26;
        req_wdata = 32'h11223344;
        check("rst_test_ready", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_test_acc0", {mem_cs, mem_wr, mem_mask}, {2'b00, 4'b1100});
        ref_b[32'h26] = 8'h44;
        ref_b[32'h27] = 8'h33;
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready_low", req_ready, 1'b0);
        check("rst_bus_idle", {mem_cs, rsp_valid}, 2'b10);
        rst  = 1'b0;
        seen = 0;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid || !mem_cs) seen++;
            @(negedge clk);
        end
        check("rst_no_activity", seen, 0);
        check("rst_word10_untouched", dmem[10], 32'hdeadbeef);
        check("rst_word9_first_half", dmem[9], 32'h3344beef);

        for (int n = 0; n < 300; n++) begin
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? LIM32 - 32'd8 + 32'($urandom_range(0, 11))
                                               : 32'($urandom_range(0, 127));
            do_req(we, 3'($urandom_range(0, 7)), addr, $urandom);
        end

        foreach (ref_b[a]) begin
            logic [31:0] w;
            w = dmem[6'(a >> 2)];
            check($sformatf("mem_byte_%0h", a), w[8*(a%4) +: 8], ref_b[a]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
